// File: rtl/count_checker_pkg.sv
// Shared definitions for the count checker: FSM state encodings and default widths.
package count_checker_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/count_checker_next.sv
// Successor of a count value in the expected direction, modulo 2^WIDTH.
module count_next #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Up counts add one, down counts subtract one; natural overflow gives the wrap.
   always_comb begin
      nxt = dir ? (x - ONE) : (x + ONE);
   end

endmodule

// File: rtl/count_checker.sv
// Receive-side observer for a free-running up/down count stream. Acquires lock
// after LOCK_N correct successors, then flags breaks, tallies them with
// saturation, and pulses on wrap-around. All outputs are registered.
module count_checker
   import count_checker_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int LOCK_N = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_valid,
   input  logic             dir,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic             wrap
);

   localparam int RUN_W = $clog2(LOCK_N + 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t           state, state_nx;
   logic [WIDTH-1:0] expected, expected_nx;
   logic [RUN_W-1:0] run, run_nx, run_inc;
   logic [ERR_W-1:0] err_count_nx;
   logic             err_nx, wrap_nx;
   logic [WIDTH-1:0] cnt_succ;
   logic [WIDTH-1:0] wrap_val;
   logic             match;

   // Saturating increment: the tally sticks at all-ones instead of rolling over.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : (v + ERR_ONE);
   endfunction

   count_next #(.WIDTH(WIDTH)) u_next (
      .x   (cnt_in),
      .dir (dir),
      .nxt (cnt_succ)
   );

   assign match    = (cnt_in == expected);
   assign run_inc  = run + RUN_ONE;
   // A matching sample equal to the far end of the range is the wrapped value.
   assign wrap_val = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   // Next-state and pulse decode; everything holds while no sample is presented.
   always_comb begin
      state_nx     = state;
      expected_nx  = expected;
      run_nx       = run;
      err_count_nx = err_count;
      err_nx       = 1'b0;
      wrap_nx      = 1'b0;
      if (cnt_valid) begin
         expected_nx = cnt_succ;
         case (state)
            SEARCH: begin
               run_nx   = '0;
               state_nx = ACQUIRE;
            end
            ACQUIRE: begin
               if (match) begin
                  run_nx = run_inc;
                  if (run_inc == RUN_LOCK) state_nx = LOCKED;
               end else begin
                  run_nx = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  wrap_nx = (cnt_in == wrap_val);
               end else begin
                  err_nx       = 1'b1;
                  err_count_nx = sat_inc(err_count);
                  run_nx       = '0;
                  state_nx     = ACQUIRE;
               end
            end
            default: begin
               run_nx   = '0;
               state_nx = SEARCH;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         expected  <= '0;
         run       <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_nx;
         expected  <= expected_nx;
         run       <= run_nx;
         locked    <= (state_nx == LOCKED);
         err       <= err_nx;
         err_count <= err_count_nx;
         wrap      <= wrap_nx;
      end
   end

endmodule
